bcd_seg_scan: RTL and testbench

//  Display stage downstream of the 10-bit binary-to-12-bit BCD converter.

---
 rtl/bcd_seg_scan.sv | 132 +++++++++++++
 tb/tb_bcd_seg_scan.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : bcd_seg_scan
// Description : Captures a 3-digit BCD word on a load strobe and scans it onto
//               a common-segment 3-digit 7-segment display (ones, tens,
//               hundreds) with leading-zero blanking. Nibbles A-F show a dash.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_seg_scan #(
    parameter int SCAN_DIV       = 50000,  // clk cycles per digit slot (>= 2)
    parameter bit SEG_ACTIVE_LOW = 1'b0,   // 1: lit segment driven low
    parameter bit AN_ACTIVE_LOW  = 1'b0    // 1: enabled digit driven low
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] bcd,
    input  logic        load,
    output logic [6:0]  seg,
    output logic [2:0]  an
);

    localparam int             c_CNT_W   = $clog2(SCAN_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [6:0]     c_SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [2:0]     c_AN_OFF  = AN_ACTIVE_LOW  ? 3'h7  : 3'h0;

    // Digit slot currently driven; the encoding doubles as the an[] bit index.
    typedef enum logic [1:0] {
        SLOT_ONES = 2'd0,
        SLOT_TENS = 2'd1,
        SLOT_HUND = 2'd2
    } slot_t;

    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    slot_t              slot_q, slot_d;
    logic [11:0]        latch_q;
    logic [6:0]         seg_q, seg_d;
    logic [2:0]         an_q, an_d;

    logic               w_tick;
    logic [3:0]         w_hun, w_ten, w_one;
    logic [3:0]         w_nib;
    logic               w_blank;
    logic [2:0]         w_an_ah;
    logic [6:0]         w_seg_ah;

    // Active-high segment pattern {g,f,e,d,c,b,a}; any non-decimal nibble is a dash.
    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = 7'b0111111;
            4'd1:    pat = 7'b0000110;
            4'd2:    pat = 7'b1011011;
            4'd3:    pat = 7'b1001111;
            4'd4:    pat = 7'b1100110;
            4'd5:    pat = 7'b1101101;
            4'd6:    pat = 7'b1111101;
            4'd7:    pat = 7'b0000111;
            4'd8:    pat = 7'b1111111;
            4'd9:    pat = 7'b1101111;
            default: pat = 7'b1000000;
        endcase
        return pat;
    endfunction

    assign w_hun = latch_q[11:8];
    assign w_ten = latch_q[7:4];
    assign w_one = latch_q[3:0];

    // Prescaler, slot sequencing and the drive pattern for the slot about to start.
    always_comb begin
        w_tick = (cnt_q == c_CNT_MAX);
        cnt_d  = w_tick ? '0 : cnt_q + 1'b1;

        case (slot_q)
            SLOT_ONES: slot_d = SLOT_TENS;
            SLOT_TENS: slot_d = SLOT_HUND;
            default:   slot_d = SLOT_ONES;
        endcase

        // Decode uses the latch as it stands before this edge, so a load that
        // coincides with a tick only becomes visible from the next slot.
        case (slot_d)
            SLOT_TENS: begin
                w_nib   = w_ten;
                w_blank = (w_hun == 4'd0) && (w_ten == 4'd0);
                w_an_ah = 3'b010;
            end
            SLOT_HUND: begin
                w_nib   = w_hun;
                w_blank = (w_hun == 4'd0);
                w_an_ah = 3'b100;
            end
            default: begin
                w_nib   = w_one;
                w_blank = 1'b0;
                w_an_ah = 3'b001;
            end
        endcase

        // A blanked digit keeps its enable so the scan duty cycle stays uniform.
        w_seg_ah = w_blank ? 7'b0000000 : f_decode(w_nib);
        seg_d    = w_seg_ah ^ {7{SEG_ACTIVE_LOW}};
        an_d     = w_an_ah  ^ {3{AN_ACTIVE_LOW}};
    end

    // State and output registers; outputs only move on tick edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            slot_q  <= SLOT_HUND;
            latch_q <= 12'h000;
            seg_q   <= c_SEG_OFF;
            an_q    <= c_AN_OFF;
        end else begin
            cnt_q <= cnt_d;
            if (load) begin
                latch_q <= bcd;
            end
            if (w_tick) begin
                slot_q <= slot_d;
                seg_q  <= seg_d;
                an_q   <= an_d;
            end
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_seg_scan
// Description : Directed, table-driven bench for bcd_seg_scan (SCAN_DIV=4,
//               active-high polarities).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_seg_scan;

    localparam int SCAN_DIV = 4;

    logic        clk;
    logic        rst;
    logic [11:0] bcd;
    logic        load;
    logic [6:0]  seg;
    logic [2:0]  an;

    int errors;
    int checks;
    int cyc;     // clk edges since the last reset release

    typedef struct {
        string      name;
        logic [11:0] bcd;
        logic [6:0] s_one;
        logic [6:0] s_ten;
        logic [6:0] s_hun;
    } vec_t;

    vec_t vecs[8];

    bcd_seg_scan #(
        .SCAN_DIV      (SCAN_DIV),
        .SEG_ACTIVE_LOW(1'b0),
        .AN_ACTIVE_LOW (1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bcd (bcd),
        .load(load),
        .seg (seg),
        .an  (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic clk_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Advance to the next tick edge (multiple of SCAN_DIV since reset release).
    task automatic to_tick();
        for (int k = 0; k < SCAN_DIV; k++) begin
            clk_step();
            if (cyc % SCAN_DIV == 0) break;
        end
    endtask

    task automatic chk(input string name, input logic [6:0] seg_exp, input logic [2:0] an_exp);
        checks++;
        if (seg !== seg_exp) begin
            errors++;
            $display("FAIL %s seg: got %b expected %b (t=%0t)", name, seg, seg_exp, $time);
        end
        checks++;
        if (an !== an_exp) begin
            errors++;
            $display("FAIL %s an: got %b expected %b (t=%0t)", name, an, an_exp, $time);
        end
    endtask

    // Reset release followed by the first scan pass of an all-zero latch.
    task automatic release_and_check(input string tag);
        rst = 1'b0;
        cyc = 0;
        for (int k = 1; k < SCAN_DIV; k++) begin
            clk_step();
            chk($sformatf("%s_idle%0d", tag, k), 7'b0000000, 3'b000);
        end
        clk_step();
        chk({tag, "_first_ones"}, 7'b0111111, 3'b001);
        to_tick();
        chk({tag, "_tens_blank"}, 7'b0000000, 3'b010);
        to_tick();
        chk({tag, "_hun_blank"}, 7'b0000000, 3'b100);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        rst    = 1'b1;
        load   = 1'b0;
        bcd    = 12'h000;

        vecs[0] = '{"v123", 12'h123, 7'b1001111, 7'b1011011, 7'b0000110};
        vecs[1] = '{"v007", 12'h007, 7'b0000111, 7'b0000000, 7'b0000000};
        vecs[2] = '{"v0A5", 12'h0A5, 7'b1101101, 7'b1000000, 7'b0000000};
        vecs[3] = '{"v100", 12'h100, 7'b0111111, 7'b0111111, 7'b0000110};
        vecs[4] = '{"v0F0", 12'h0F0, 7'b0111111, 7'b1000000, 7'b0000000};
        vecs[5] = '{"v080", 12'h080, 7'b0111111, 7'b1111111, 7'b0000000};
        vecs[6] = '{"v468", 12'h468, 7'b1111111, 7'b1111101, 7'b1100110};
        vecs[7] = '{"v123", 12'h123, 7'b1001111, 7'b1011011, 7'b0000110};

        // Reset state before and across clock edges.
        #2;
        chk("rst_async", 7'b0000000, 3'b000);
        clk_step();
        clk_step();
        chk("rst_held", 7'b0000000, 3'b000);

        release_and_check("boot");

        // Table: load just after a hundreds tick, then check the full next pass.
        foreach (vecs[i]) begin
            bcd  = vecs[i].bcd;
            load = 1'b1;
            clk_step();
            load = 1'b0;
            to_tick();
            chk({vecs[i].name, "_ones"}, vecs[i].s_one, 3'b001);
            clk_step();
            chk({vecs[i].name, "_hold"}, vecs[i].s_one, 3'b001);
            to_tick();
            chk({vecs[i].name, "_tens"}, vecs[i].s_ten, 3'b010);
            to_tick();
            chk({vecs[i].name, "_hun"}, vecs[i].s_hun, 3'b100);
        end

        // Second pass of 123 without reloading: the scan repeats.
        to_tick();
        chk("rep_ones", 7'b1001111, 3'b001);
        to_tick();
        chk("rep_tens", 7'b1011011, 3'b010);
        to_tick();
        chk("rep_hun", 7'b0000110, 3'b100);

        // Load 999 on the same edge as the ones tick: old digit shown there.
        while (cyc % SCAN_DIV != SCAN_DIV - 1) clk_step();
        bcd  = 12'h999;
        load = 1'b1;
        clk_step();
        load = 1'b0;
        chk("coinc_old_ones", 7'b1001111, 3'b001);
        to_tick();
        chk("coinc_tens9", 7'b1101111, 3'b010);
        to_tick();
        chk("coinc_hun9", 7'b1101111, 3'b100);
        to_tick();
        chk("coinc_ones9", 7'b1101111, 3'b001);

        // Back-to-back loads inside one slot: the last one wins.
        clk_step();
        bcd  = 12'h111;
        load = 1'b1;
        clk_step();
        bcd  = 12'h222;
        clk_step();
        load = 1'b0;
        bcd  = 12'h000;
        to_tick();
        chk("b2b_tens2", 7'b1011011, 3'b010);
        to_tick();
        chk("b2b_hun2", 7'b1011011, 3'b100);

        // Reset asserted mid tens slot: outputs drop without a clock edge.
        to_tick();
        to_tick();
        chk("pre_rst_tens", 7'b1011011, 3'b010);
        clk_step();
        #2;
        rst = 1'b1;
        #1;
        chk("midscan_rst", 7'b0000000, 3'b000);
        clk_step();
        chk("midscan_rst_held", 7'b0000000, 3'b000);
        release_and_check("rerun");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
